// File: rtl/imm_lut_pkg.sv
// imm_lut_pkg: shared sizes, immediate table contents and encoder state type
package imm_lut_pkg;
  localparam int NUM_ENTRIES = 27;
  localparam int IDX_W = 5;
  localparam int VAL_W = 8;
  localparam logic [VAL_W-1:0] IMM_TABLE [NUM_ENTRIES] = '{
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
    8'd14, 8'd16, 8'd30, 8'd31, 8'd32, 8'd33, 8'd60, 8'd91, 8'd109,
    8'd142, 8'd170, 8'd204, 8'd224, 8'd225, 8'd240, 8'd247, 8'd254, 8'd85, 8'd171, 8'd90
  };
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
endpackage

// File: rtl/imm_table_rom.sv
// imm_table_rom: combinational index-to-value read of the immediate table
module imm_table_rom
  import imm_lut_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [VAL_W-1:0] data
);
  assign data = (addr < IDX_W'(NUM_ENTRIES)) ? IMM_TABLE[addr] : '0;
endmodule

// File: rtl/imm_lut_encoder.sv
// imm_lut_encoder: sequential value-to-index scanner with a one-entry last-hit cache
module imm_lut_encoder
  import imm_lut_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  input  logic [VAL_W-1:0] req_value,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_index,
  output logic             busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] scan_idx, cache_index;
  logic [VAL_W-1:0] val_q, cache_value, rom_data;
  logic cache_valid, match, cache_hit, accept;
  imm_table_rom u_rom (.addr(scan_idx), .data(rom_data));
  assign match = rom_data == val_q;
  assign accept = req_valid && req_ready;
  assign cache_hit = cache_valid && req_value == cache_value;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? SEARCH : IDLE;
      SEARCH:  state_n = (match || scan_idx == LAST) ? RESP : SEARCH;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // A cache hit starts the scan at the cached index, so it confirms on the first compare
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      scan_idx <= '0;
      val_q <= '0;
      rsp_hit <= 1'b0;
      rsp_index <= '0;
      cache_valid <= 1'b0;
      cache_value <= '0;
      cache_index <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        val_q <= req_value;
        scan_idx <= cache_hit ? cache_index : '0;
      end else if (state == SEARCH && !match && scan_idx != LAST) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if (state == SEARCH && match) begin
        rsp_hit <= 1'b1;
        rsp_index <= scan_idx;
        cache_valid <= 1'b1;
        cache_value <= val_q;
        cache_index <= scan_idx;
      end else if (state == SEARCH && scan_idx == LAST) begin
        rsp_hit <= 1'b0;
        rsp_index <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imm_lut_encoder.sv
// tb_imm_lut_encoder: random lookups checked against a table-search reference model
module tb_imm_lut_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [7:0] req_value = '0;
  logic req_ready, rsp_valid, rsp_hit, busy;
  logic rsp_ready = 1'b0;
  logic [4:0] rsp_index;
  int n_cmp = 0;
  int n_bad = 0;
  int ref_table [27] = '{0, 1, 2, 3, 4, 5, 6, 14, 16, 30, 31, 32, 33, 60, 91, 109,
                         142, 170, 204, 224, 225, 240, 247, 254, 85, 171, 90};
  bit m_cache_valid = 0;
  int m_cache_value = 0;

  imm_lut_encoder dut (
    .Clk(clk), .Reset(rst_n), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_index(rsp_index), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int find_idx(input int v);
    for (int i = 0; i < 27; i++) if (ref_table[i] == v) return i;
    return -1;
  endfunction

  task automatic lookup(input int v, input int hold);
    int k, lat, exp_lat;
    bit all_busy, stable;
    k = find_idx(v);
    exp_lat = (m_cache_valid && m_cache_value == v) ? 1 : (k >= 0 ? k + 1 : 27);
    @(negedge clk);
    check("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_value = 8'(v);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_value = 8'($urandom);
    lat = 0;
    all_busy = 1;
    while (!rsp_valid && lat < 100) begin
      if (!busy || req_ready) all_busy = 0;
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency v=%0d", v), lat, exp_lat);
    check("busy_during", int'(all_busy && busy && !req_ready), 1);
    check($sformatf("hit v=%0d", v), int'(rsp_hit), k >= 0 ? 1 : 0);
    check($sformatf("index v=%0d", v), int'(rsp_index), k >= 0 ? k : 0);
    stable = 1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || req_ready || !busy || rsp_hit != (k >= 0) ||
          int'(rsp_index) != (k >= 0 ? k : 0)) stable = 0;
    end
    if (hold > 0) check("hold_stable", int'(stable), 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("back_idle", int'({rsp_valid, busy, req_ready}), 1);
    if (k >= 0) begin
      m_cache_valid = 1;
      m_cache_value = v;
    end
  endtask

  initial begin
    int v, prev;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hit", int'(rsp_hit), 0);
    check("rst_index", int'(rsp_index), 0);
    rst_n = 1'b1;
    lookup(0, 0);
    lookup(91, 0);
    lookup(255, 0);
    lookup(254, 0);
    lookup(254, 0);
    lookup(171, 5);
    @(negedge clk);
    req_valid = 1'b1;
    req_value = 8'd224;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_search_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_outputs", int'({rsp_valid, busy, rsp_hit, rsp_index}), 0);
    rst_n = 1'b1;
    m_cache_valid = 0;
    lookup(224, 0);
    prev = 0;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0, 1: v = ref_table[$urandom_range(0, 26)];
        2: v = prev;
        default: v = $urandom_range(0, 255);
      endcase
      lookup(v, $urandom_range(0, 3));
      prev = v;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
